prod_accum: RTL

PROD_ACCUM -- requirements
Module: prod_accum

---
 rtl/prod_accum_pkg.sv | 20 ++
 rtl/prod_accum.sv | 106 ++++++++++
 2 files changed

// File: rtl/prod_accum_pkg.sv
// Shared definitions for the product accumulator: state encoding and
// default sizing constants.
package prod_accum_pkg;

    // Controller states: collecting terms, or holding a finished result.
    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_t;

    // Default number of products summed per result.
    localparam int unsigned N_DEFAULT     = 8;

    // Default signed accumulator / result width.
    localparam int unsigned ACC_W_DEFAULT = 12;

    // Width of the signed product arriving from the multiplier stage.
    localparam int unsigned PRODUCT_W     = 8;

endpackage

// File: rtl/prod_accum.sv
// Product accumulator: sums N signed 8-bit products into a signed ACC_W-bit
// result with a sticky overflow flag, then holds it under valid/ready
// handshake until consumed.
module prod_accum
    import prod_accum_pkg::*;
#(
    parameter int unsigned N     = N_DEFAULT,
    parameter int unsigned ACC_W = ACC_W_DEFAULT
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [PRODUCT_W-1:0]        product,
    input  logic                        clear,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [ACC_W-1:0]     sum,
    output logic                        ovf
);

    // Counter is just wide enough to hold the value N.
    localparam int unsigned       CNT_W    = $clog2(N + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    state_t                    state_q, state_d;
    logic signed [ACC_W-1:0]   sum_q,   sum_d;
    logic                      ovf_q,   ovf_d;
    logic [CNT_W-1:0]          cnt_q,   cnt_d;

    logic signed [ACC_W-1:0]   term;
    logic signed [ACC_W-1:0]   add_res;
    logic                      add_ovf;

    // Sign-extended term, wrapped sum and two's-complement overflow detect.
    always_comb begin
        term    = ACC_W'($signed(product));
        add_res = sum_q + term;
        add_ovf = (sum_q[ACC_W-1] == term[ACC_W-1]) &&
                  (add_res[ACC_W-1] != sum_q[ACC_W-1]);
    end

    // Next-state, datapath update and handshake outputs.
    always_comb begin
        state_d   = state_q;
        sum_d     = sum_q;
        ovf_d     = ovf_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;

        case (state_q)
            ACCUM: begin
                in_ready = ~clear;
                if (clear) begin
                    // A term offered alongside clear is dropped.
                    sum_d = '0;
                    ovf_d = 1'b0;
                    cnt_d = '0;
                end else if (in_valid) begin
                    sum_d = add_res;
                    ovf_d = ovf_q | add_ovf;
                    cnt_d = cnt_q + CNT_ONE;
                    if (cnt_q == CNT_LAST) begin
                        state_d = DONE;
                    end
                end
            end

            DONE: begin
                out_valid = 1'b1;
                // Result and flag hold until taken; clear has no effect here.
                if (out_ready) begin
                    sum_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = ACCUM;
                end
            end

            default: begin
                state_d = ACCUM;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACCUM;
            sum_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign sum = sum_q;
    assign ovf = ovf_q;

endmodule
